// File: rtl/tx_resp_buffer.sv
// tx_resp_buffer: response byte FIFO between the system controller and the
// UART TX data synchronizer. Words of one or two bytes are queued, then issued
// one byte at a time. The synchronized TX busy flag acts as the handshake.
module tx_resp_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int PTR_WIDTH    = $clog2(FIFO_DEPTH),
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [2*DATA_WIDTH-1:0]   IN_DATA,
  input  logic                      IN_TWO_BYTES,
  input  logic                      IN_VLD,
  output logic                      IN_READY,
  input  logic                      busy,
  output logic [DATA_WIDTH-1:0]     TX_P_DATA,
  output logic                      TX_D_VLD,
  output logic [PTR_WIDTH:0]        FIFO_CNT,
  output logic                      OVF_ERR,
  output logic                      TMO_ERR
);

  localparam int CNT_W = PTR_WIDTH + 1;
  localparam int TMO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_HI = 2'd1,
    S_WAIT_LO = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf;
  logic                  r_tmo;
  logic                  r_tx_vld;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic [TMO_W-1:0]      r_tmo_cnt;
  state_t                r_state;

  state_t                w_state_next;
  logic                  w_vld_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [TMO_W-1:0]      w_tmo_cnt_next;
  logic                  w_tmo_next;
  logic                  w_pop;
  logic                  w_ready;
  logic                  w_push;
  logic [CNT_W-1:0]      w_push_n;
  logic [PTR_WIDTH-1:0]  w_wr_ptr_p1;

  // Two free entries are required so a two-byte word always fits.
  assign w_ready     = (r_cnt <= CNT_W'(FIFO_DEPTH - 2));
  assign w_push      = IN_VLD & w_ready;
  assign w_push_n    = !w_push ? '0 : (IN_TWO_BYTES ? CNT_W'(2) : CNT_W'(1));
  assign w_wr_ptr_p1 = r_wr_ptr + PTR_WIDTH'(1);

  assign IN_READY  = w_ready;
  assign FIFO_CNT  = r_cnt;
  assign OVF_ERR   = r_ovf;
  assign TMO_ERR   = r_tmo;
  assign TX_D_VLD  = r_tx_vld;
  assign TX_P_DATA = r_tx_data;

  // Storage: low byte at wr_ptr, optional high byte at wr_ptr+1 (no reset needed).
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= IN_DATA[DATA_WIDTH-1:0];
      if (IN_TWO_BYTES) begin
        r_mem[w_wr_ptr_p1] <= IN_DATA[2*DATA_WIDTH-1:DATA_WIDTH];
      end
    end
  end

  // Pointers, occupancy and overflow flag; push and pop may share a cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_push_n[PTR_WIDTH-1:0];
      r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(w_pop);
      r_cnt    <= r_cnt + w_push_n - CNT_W'(w_pop);
      r_ovf    <= IN_VLD & ~w_ready;
    end
  end

  // Issue FSM state and its registered outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_tx_vld  <= 1'b0;
      r_tx_data <= '0;
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tx_vld  <= w_vld_next;
      r_tx_data <= w_data_next;
      r_tmo_cnt <= w_tmo_cnt_next;
      r_tmo     <= w_tmo_next;
    end
  end

  // Next state: issue from IDLE, wait for busy to rise (or time out), then fall.
  always_comb begin
    w_state_next   = r_state;
    w_vld_next     = r_tx_vld;
    w_data_next    = r_tx_data;
    w_tmo_cnt_next = r_tmo_cnt;
    w_tmo_next     = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_cnt != '0) begin
          w_pop          = 1'b1;
          w_data_next    = r_mem[r_rd_ptr];
          w_vld_next     = 1'b1;
          w_tmo_cnt_next = '0;
          w_state_next   = S_WAIT_HI;
        end else begin
          w_vld_next = 1'b0;
        end
      end
      S_WAIT_HI: begin
        if (busy) begin
          w_vld_next   = 1'b0;
          w_state_next = S_WAIT_LO;
        end else if (r_tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
          // Busy never answered: drop this byte and move on.
          w_vld_next   = 1'b0;
          w_tmo_next   = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          w_tmo_cnt_next = r_tmo_cnt + TMO_W'(1);
        end
      end
      S_WAIT_LO: begin
        if (!busy) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_vld_next   = 1'b0;
      end
    endcase
  end

endmodule
